// File: rtl/flash_kick_pkg.sv
// Shared definitions for the kickstart/flash bus timing logic.
// Holds the FSM state encoding, the default phase lengths and a helper that
// clamps a phase length so a zero-length phase still lasts one cycle.
package flash_kick_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_RD_DONE,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_WR_DONE
  } state_t;

  localparam int DEF_RD_WAIT  = 3;
  localparam int DEF_WR_SETUP = 1;
  localparam int DEF_WR_PULSE = 3;
  localparam int DEF_WR_HOLD  = 1;

  // Number of CLK cycles a phase with parameter value p actually lasts.
  function automatic int phase_len(input int p);
    return (p < 1) ? 1 : p;
  endfunction

endpackage

// File: rtl/flash_sync.sv
// N-flop synchroniser for a single asynchronous level.
// Ports: clk, rst_n (async, active-low), d (async input), rst_val (value
// loaded into every stage on reset), q (synchronised output).
module flash_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  input  logic rst_val,
  output logic q
);

  logic [N-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= {N{rst_val}};
    end else begin
      sr <= {sr[N-2:0], d};
    end
  end

  assign q = sr[N-1];

endmodule

// File: rtl/flash_bus_timing_ctrl.sv
// Flash strobe / DTACK generator: turns decoded read/write qualifiers plus the
// raw 68000 strobes into CLK-timed FLASH_RD_n, FLASH_WR_n and DTACK.
// Ports: CLK, RESET_n (async active-low), CPU_AS_n/UDS_n/LDS_n (raw bus
// strobes), ACC_RD/ACC_WR (decoder), FLASH_RD_n/FLASH_WR_n ({upper,lower},
// active-low), DTACK_n/DTACK_OE (DTACK value and drive enable), BUSY.
module flash_bus_timing_ctrl
  import flash_kick_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int RD_WAIT     = DEF_RD_WAIT,
  parameter int WR_SETUP    = DEF_WR_SETUP,
  parameter int WR_PULSE    = DEF_WR_PULSE,
  parameter int WR_HOLD     = DEF_WR_HOLD,
  parameter int CNT_W       = 4
) (
  input  logic       CLK,
  input  logic       RESET_n,
  input  logic       CPU_AS_n,
  input  logic       UDS_n,
  input  logic       LDS_n,
  input  logic       ACC_RD,
  input  logic       ACC_WR,
  output logic [1:0] FLASH_RD_n,
  output logic [1:0] FLASH_WR_n,
  output logic       DTACK_n,
  output logic       DTACK_OE,
  output logic       BUSY
);

  // Counter load values: a phase of L cycles counts L-1 down to 0.
  localparam logic [CNT_W-1:0] LD_RD = CNT_W'(phase_len(RD_WAIT) - 1);
  localparam logic [CNT_W-1:0] LD_SU = CNT_W'(phase_len(WR_SETUP) - 1);
  localparam logic [CNT_W-1:0] LD_PU = CNT_W'(phase_len(WR_PULSE) - 1);
  localparam logic [CNT_W-1:0] LD_HO = CNT_W'(phase_len(WR_HOLD) - 1);

  logic as_s;

  flash_sync #(.N(SYNC_STAGES)) u_as_sync (
    .clk     (CLK),
    .rst_n   (RESET_n),
    .d       (CPU_AS_n),
    .rst_val (1'b1),
    .q       (as_s)
  );

  state_t           state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic [1:0]       strb, nxt_strb;
  logic             abort, nxt_abort;
  logic             done;
  logic [1:0]       rd_q, wr_q;
  logic             dtack_q, oe_q, busy_q;

  assign done = (cnt == '0);

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_strb  = strb;
    nxt_abort = abort;
    case (state)
      S_IDLE: begin
        nxt_abort = 1'b0;
        // ACC_RD and ACC_WR together is a decode error: no access starts.
        if (!as_s && ACC_RD && !ACC_WR) begin
          nxt_state = S_RD_WAIT;
          nxt_cnt   = LD_RD;
          nxt_strb  = {UDS_n, LDS_n};
        end else if (!as_s && ACC_WR && !ACC_RD) begin
          nxt_state = S_WR_SETUP;
          nxt_cnt   = LD_SU;
          nxt_strb  = {UDS_n, LDS_n};
        end
      end
      S_RD_WAIT: begin
        if (as_s) begin
          nxt_state = S_IDLE;
          nxt_cnt   = '0;
        end else if (done) begin
          nxt_state = S_RD_DONE;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt - CNT_W'(1);
        end
      end
      S_WR_SETUP: begin
        if (as_s) begin
          nxt_state = S_IDLE;
          nxt_cnt   = '0;
        end else if (done) begin
          nxt_state = S_WR_PULSE;
          nxt_cnt   = LD_PU;
        end else begin
          nxt_cnt = cnt - CNT_W'(1);
        end
      end
      // Once WE has fallen the pulse and hold always complete; an abort is
      // only remembered so the cycle ends without DTACK.
      S_WR_PULSE: begin
        nxt_abort = abort | as_s;
        if (done) begin
          nxt_state = S_WR_HOLD;
          nxt_cnt   = LD_HO;
        end else begin
          nxt_cnt = cnt - CNT_W'(1);
        end
      end
      S_WR_HOLD: begin
        nxt_abort = abort | as_s;
        if (done) begin
          nxt_state = (abort || as_s) ? S_IDLE : S_WR_DONE;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt - CNT_W'(1);
        end
      end
      S_RD_DONE, S_WR_DONE: begin
        if (as_s) begin
          nxt_state = S_IDLE;
          nxt_cnt   = '0;
        end
      end
      default: begin
        nxt_state = S_IDLE;
        nxt_cnt   = '0;
      end
    endcase
  end

  // State plus outputs registered from the next-state decode.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      strb    <= 2'b11;
      abort   <= 1'b0;
      rd_q    <= 2'b11;
      wr_q    <= 2'b11;
      dtack_q <= 1'b1;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= nxt_state;
      cnt     <= nxt_cnt;
      strb    <= nxt_strb;
      abort   <= nxt_abort;
      rd_q    <= (nxt_state == S_RD_WAIT || nxt_state == S_RD_DONE) ? nxt_strb : 2'b11;
      wr_q    <= (nxt_state == S_WR_PULSE) ? nxt_strb : 2'b11;
      dtack_q <= !(nxt_state == S_RD_DONE || nxt_state == S_WR_DONE);
      oe_q    <= (nxt_state == S_RD_DONE || nxt_state == S_WR_DONE);
      busy_q  <= (nxt_state != S_IDLE);
    end
  end

  // Read strobe and DTACK drop the instant the CPU releases AS_n; WE is
  // left alone so a write pulse is never cut short.
  assign FLASH_RD_n = rd_q | {2{CPU_AS_n}};
  assign FLASH_WR_n = wr_q;
  assign DTACK_n    = dtack_q | CPU_AS_n;
  assign DTACK_OE   = oe_q & ~CPU_AS_n;
  assign BUSY       = busy_q;

endmodule
